// File: rtl/sipo_pkg.sv
// Shared types for the serial-in/parallel-out deserializer.
// Holds the default word width and the output buffer state encoding.
package sipo_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_e;

endpackage

// File: rtl/sipo_out_buf.sv
// One-deep valid/ready holding register for assembled words.
// Ports: clk, rst (async active-low), i_clear (sync flush),
//   i_load/i_word (completed word strobe), i_ready (consumer accept),
//   o_data (held word), o_valid (word pending), o_drop (word lost).
module sipo_out_buf
    import sipo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_word,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_drop
);

    buf_state_e       r_state;
    buf_state_e       w_state_nxt;
    logic [WIDTH-1:0] r_data;
    logic             w_take;
    logic             w_drop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= BUF_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Data only moves on a load; flush leaves the last word visible.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data <= '0;
        end else if (w_take) begin
            r_data <= i_word;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_drop      = 1'b0;
        if (i_clear) begin
            w_state_nxt = BUF_EMPTY;
        end else begin
            unique case (r_state)
                BUF_EMPTY: begin
                    if (i_load) begin
                        w_take      = 1'b1;
                        w_state_nxt = BUF_FULL;
                    end
                end
                BUF_FULL: begin
                    // Handshake and new word on one edge: refill, no bubble.
                    if (i_load) begin
                        if (i_ready) begin
                            w_take = 1'b1;
                        end else begin
                            w_drop = 1'b1;
                        end
                    end else if (i_ready) begin
                        w_state_nxt = BUF_EMPTY;
                    end
                end
            endcase
        end
    end

    assign o_data  = r_data;
    assign o_valid = (r_state == BUF_FULL);
    assign o_drop  = w_drop;

endmodule

// File: rtl/sipo_deserializer.sv
// LSB-first serial to WIDTH-bit parallel deserializer with 1-deep output.
// Ports: clk, rst (async active-low), serial_in/bit_valid (bit stream),
//   clear (sync flush), parallel_out/out_valid/out_ready (word handshake),
//   overrun (sticky word-lost flag), bit_count (bits in partial word).
module sipo_deserializer
    import sipo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_in,
    input  logic             bit_valid,
    input  logic             clear,
    output logic [WIDTH-1:0] parallel_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    output logic [CNT_W-1:0] bit_count
);

    // Bit 0 of the shift register is always shifted past before use,
    // so only the upper WIDTH-1 bits are stored.
    logic [WIDTH-2:0] r_shift;
    logic [CNT_W-1:0] r_cnt;
    logic             r_overrun;

    logic             w_accept;
    logic             w_last;
    logic             w_done;
    logic [WIDTH-1:0] w_word;
    logic             w_drop;

    assign w_accept = bit_valid && !clear;
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_done   = w_accept && w_last;
    assign w_word   = {serial_in, r_shift};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (clear) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (bit_valid) begin
            r_shift <= w_word[WIDTH-1:1];
            r_cnt   <= w_last ? '0 : r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overrun <= 1'b0;
        end else if (clear) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end
    end

    sipo_out_buf #(
        .WIDTH (WIDTH)
    ) u_out_buf (
        .clk     (clk),
        .rst     (rst),
        .i_clear (clear),
        .i_load  (w_done),
        .i_word  (w_word),
        .i_ready (out_ready),
        .o_data  (parallel_out),
        .o_valid (out_valid),
        .o_drop  (w_drop)
    );

    assign overrun   = r_overrun;
    assign bit_count = r_cnt;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Self-checking bench for sipo_deserializer (WIDTH=4).
// Directed table, corner sequences and a random run vs a queue model.
module tb_sipo_deserializer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         serial_in;
    logic         bit_valid;
    logic         clear;
    logic         out_ready;
    logic [W-1:0] parallel_out;
    logic         out_valid;
    logic         overrun;
    logic [1:0]   bit_count;

    int n_err = 0;
    int n_chk = 0;

    // Reference model: bits collected so far, buffer content, flag.
    bit       m_bits[$];
    bit       m_full;
    bit [W-1:0] m_data;
    bit       m_ovr;

    typedef struct {
        bit       bv;
        bit       si;
        bit       clr;
        bit       rdy;
        bit       e_v;
        bit [3:0] e_d;
        bit       e_o;
        bit [1:0] e_c;
    } vec_t;

    vec_t tbl[$];

    sipo_deserializer #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .serial_in    (serial_in),
        .bit_valid    (bit_valid),
        .clear        (clear),
        .parallel_out (parallel_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .overrun      (overrun),
        .bit_count    (bit_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_bits.delete();
        m_full = 1'b0;
        m_data = '0;
        m_ovr  = 1'b0;
    endtask

    task automatic model_edge(input bit bv, input bit si,
                              input bit clr, input bit rdy);
        bit         done;
        bit [W-1:0] word;
        done = 1'b0;
        word = '0;
        if (clr) begin
            m_bits.delete();
            m_full = 1'b0;
            m_ovr  = 1'b0;
        end else begin
            if (bv) begin
                m_bits.push_back(si);
                if (m_bits.size() == W) begin
                    for (int i = 0; i < W; i++)
                        word = word | (W'(m_bits[i]) << i);
                    m_bits.delete();
                    done = 1'b1;
                end
            end
            if (done) begin
                if (!m_full || rdy) begin
                    m_data = word;
                    m_full = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (m_full && rdy) begin
                m_full = 1'b0;
            end
        end
    endtask

    task automatic model_check(input string tag);
        check({tag, ".valid"}, out_valid, m_full);
        check({tag, ".data"}, parallel_out, m_data);
        check({tag, ".ovr"}, overrun, m_ovr);
        check({tag, ".cnt"}, bit_count, m_bits.size());
    endtask

    task automatic step(input bit bv, input bit si,
                        input bit clr, input bit rdy, input string tag);
        @(negedge clk);
        bit_valid = bv;
        serial_in = si;
        clear     = clr;
        out_ready = rdy;
        @(posedge clk);
        model_edge(bv, si, clr, rdy);
        #1;
        model_check(tag);
    endtask

    task automatic add(input bit bv, input bit si, input bit clr,
                       input bit rdy, input bit ev, input bit [3:0] ed,
                       input bit eo, input bit [1:0] ec);
        vec_t v;
        v = '{bv, si, clr, rdy, ev, ed, eo, ec};
        tbl.push_back(v);
    endtask

    initial begin
        bit b4[4];
        rst       = 1'b0;
        serial_in = 1'b0;
        bit_valid = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b0;
        model_reset();

        // Basic word 0,1,0,1 -> A, one-cycle valid
        add(1,0,0,1, 0,4'h0,0,1);
        add(1,1,0,1, 0,4'h0,0,2);
        add(1,0,0,1, 0,4'h0,0,3);
        add(1,1,0,1, 1,4'hA,0,0);
        add(0,0,0,1, 0,4'hA,0,0);
        // Back-pressure: 5 held, C dropped
        add(1,1,0,0, 0,4'hA,0,1);
        add(1,0,0,0, 0,4'hA,0,2);
        add(1,1,0,0, 0,4'hA,0,3);
        add(1,0,0,0, 1,4'h5,0,0);
        add(1,0,0,0, 1,4'h5,0,1);
        add(1,0,0,0, 1,4'h5,0,2);
        add(1,1,0,0, 1,4'h5,0,3);
        add(1,1,0,0, 1,4'h5,1,0);
        add(0,0,0,1, 0,4'h5,1,0);
        // Clear drops sticky overrun
        add(0,0,1,1, 0,4'h5,0,0);
        // Stream 1,2,3 with out_ready=1
        add(1,1,0,1, 0,4'h5,0,1);
        add(1,0,0,1, 0,4'h5,0,2);
        add(1,0,0,1, 0,4'h5,0,3);
        add(1,0,0,1, 1,4'h1,0,0);
        add(1,0,0,1, 0,4'h1,0,1);
        add(1,1,0,1, 0,4'h1,0,2);
        add(1,0,0,1, 0,4'h1,0,3);
        add(1,0,0,1, 1,4'h2,0,0);
        add(1,1,0,1, 0,4'h2,0,1);
        add(1,1,0,1, 0,4'h2,0,2);
        add(1,0,0,1, 0,4'h2,0,3);
        add(1,0,0,1, 1,4'h3,0,0);
        add(0,0,0,1, 0,4'h3,0,0);
        // Mid-word clear (clear wins over bit_valid), then 1,0,0,0
        add(1,1,0,1, 0,4'h3,0,1);
        add(1,1,0,1, 0,4'h3,0,2);
        add(1,1,1,1, 0,4'h3,0,0);
        add(1,1,0,1, 0,4'h3,0,1);
        add(1,0,0,1, 0,4'h3,0,2);
        add(1,0,0,1, 0,4'h3,0,3);
        add(1,0,0,1, 1,4'h1,0,0);
        add(0,0,0,1, 0,4'h1,0,0);

        #2;
        check("rst.valid", out_valid, 0);
        check("rst.data", parallel_out, 0);
        check("rst.ovr", overrun, 0);
        check("rst.cnt", bit_count, 0);
        @(negedge clk);
        rst = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].bv, tbl[i].si, tbl[i].clr, tbl[i].rdy, "tbl_model");
            check($sformatf("tbl%0d.valid", i), out_valid, tbl[i].e_v);
            check($sformatf("tbl%0d.data", i), parallel_out, tbl[i].e_d);
            check($sformatf("tbl%0d.ovr", i), overrun, tbl[i].e_o);
            check($sformatf("tbl%0d.cnt", i), bit_count, tbl[i].e_c);
        end

        // Gapped input 1,1,0,0 with 3 idle cycles between bits
        b4 = '{1, 1, 0, 0};
        for (int k = 0; k < 4; k++) begin
            step(1, b4[k], 0, 1, "gap_model");
            check($sformatf("gap%0d.cnt", k), bit_count, (k + 1) % 4);
            if (k == 3) begin
                check("gap.valid", out_valid, 1);
                check("gap.data", parallel_out, 4'h3);
            end else begin
                for (int g = 0; g < 3; g++) begin
                    step(0, 1, 0, 1, "gap_idle");
                    check("gap.hold", bit_count, k + 1);
                end
            end
        end

        // Async reset mid-word while FULL
        step(0, 0, 0, 1, "ar_drain");
        for (int k = 0; k < 4; k++) step(1, k[0], 0, 0, "ar_fill");
        step(1, 1, 0, 0, "ar_part");
        step(1, 1, 0, 0, "ar_part");
        check("ar.full", out_valid, 1);
        @(negedge clk);
        bit_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("ar.valid", out_valid, 0);
        check("ar.data", parallel_out, 0);
        check("ar.ovr", overrun, 0);
        check("ar.cnt", bit_count, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        b4 = '{0, 1, 1, 0};
        for (int k = 0; k < 4; k++) step(1, b4[k], 0, 1, "ar_word");
        check("ar.word", parallel_out, 4'h6);
        check("ar.wvalid", out_valid, 1);

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 9) < 7, 1'($urandom),
                 $urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1,
                 "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
